gf_seq_mult: RTL

//  Iterative, digit-serial multiplier with three modes behind one valid/ready interface:
//  - unsigned integer multiply
//  - GF(2)[x] carry-less multiply
//  - GF(2^W) multiply reduced by a run-time polynomial

---
 rtl/gf_seq_mult.sv | 95 +++++++++
 1 files changed

// File: rtl/gf_seq_mult.sv
// gf_seq_mult: digit-serial integer / carry-less / GF(2^W) multiplier with valid/ready handshake
// Ports: clk, rst_n (async, active-low); in_valid/in_ready request handshake carrying mode, a, b, poly;
// out_valid/out_ready result handshake carrying out (2W bits); busy high whenever not IDLE.
module gf_seq_mult #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic [DATA_WIDTH-1:0]     poly,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out,
  output logic                      busy
);
  localparam int W = DATA_WIDTH;
  localparam int D = DIGIT_WIDTH;
  localparam int N_MUL = W / D;
  localparam int N_RED = (W + D - 2) / D;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, MUL, RED, DONE} state_t;
  state_t state, state_n;
  logic [2*W-1:0] acc, a_sh, mul_nx, red_nx, pw;
  logic [W-1:0] b_sh, poly_r;
  logic [1:0] mode_r;
  logic [CW-1:0] cnt;
  logic last_mul, last_red, int_m, red_m;
  assign int_m = mode_r[0] == mode_r[1];
  assign red_m = mode_r == 2'b10;
  assign last_mul = cnt == CW'(N_MUL - 1);
  assign last_red = cnt == CW'(N_RED - 1);
  // a_sh already carries the k*D offset, so digit bit i only needs a further shift by i
  always_comb begin
    mul_nx = acc;
    for (int i = 0; i < D; i++)
      if (b_sh[i]) mul_nx = int_m ? mul_nx + (a_sh << i) : mul_nx ^ (a_sh << i);
  end
  // bits are folded MSB first and sequentially, so a bit toggled by a higher fold is seen
  always_comb begin
    int j;
    red_nx = acc;
    pw = {{(W-1){1'b0}}, 1'b1, poly_r};
    for (int i = 0; i < D; i++) begin
      j = 2*W - 2 - int'(cnt) * D - i;
      if (j >= W && red_nx[j]) red_nx = red_nx ^ (pw << (j - W));
    end
  end
  always_comb begin
    state_n = state;
    in_ready = state == IDLE;
    busy = state != IDLE;
    out_valid = state == DONE;
    if (state == IDLE && in_valid) state_n = MUL;
    else if (state == MUL && last_mul) state_n = red_m ? RED : DONE;
    else if (state == RED && last_red) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // out is a separate register so it keeps the previous result while the next request runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
      poly_r <= '0;
      mode_r <= '0;
      cnt <= '0;
      out <= '0;
    end else if (state == IDLE && in_valid) begin
      acc <= '0;
      a_sh <= {{W{1'b0}}, a};
      b_sh <= b;
      poly_r <= poly;
      mode_r <= mode;
      cnt <= '0;
    end else if (state == MUL) begin
      acc <= mul_nx;
      a_sh <= a_sh << D;
      b_sh <= b_sh >> D;
      cnt <= last_mul ? '0 : cnt + CW'(1);
      if (last_mul && !red_m) out <= mul_nx;
    end else if (state == RED) begin
      acc <= red_nx;
      cnt <= cnt + CW'(1);
      if (last_red) out <= red_nx;
    end
  end
endmodule
